// File: rtl/serial_alu_seq_if.sv
// Operation request / result bus for the bit-serial ALU sequencer.
// The master issues start with its operands; the slave returns the handshake, the result and the flags.
interface serial_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, A, B, control,
    input  busy, done, out, carryout, overflow, zero, negative
  );

  modport slave (
    input  start, A, B, control,
    output busy, done, out, carryout, overflow, zero, negative
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: a single 1-bit slice processes one operand bit per clock. The ripple carry is held
// in a flop between bits, and the result plus its flags are published together when the last bit finishes.
module serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  serial_alu_seq_if.slave bus
);
  localparam int             IW          = $clog2(WIDTH);
  localparam logic [IW-1:0]  LAST_IDX    = IW'(WIDTH - 1);
  localparam logic [IW-1:0]  PRE_MSB_IDX = IW'(WIDTH - 2);
  localparam logic [IW-1:0]  IDX_ONE     = IW'(1);
  localparam logic [1:0]     ST_IDLE     = 2'd0;
  localparam logic [1:0]     ST_RUN      = 2'd1;
  localparam logic [1:0]     ST_DONE     = 2'd2;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       ctrl_r;
  logic [IW-1:0]    idx_r;
  logic             carry_r;
  logic             c_in_msb_r;
  logic [WIDTH-1:0] res_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] out_r;
  logic             carryout_r;
  logic             overflow_r;
  logic             zero_r;
  logic             negative_r;

  logic             arith_s;
  logic             illegal_s;
  logic             b_bit_s;
  logic [1:0]       slice_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;

  // One-bit ALU slice; returns {carry_out, result}. b arrives already inverted for SUB.
  function automatic logic [1:0] alu_slice(input logic a, input logic b, input logic cin,
                                           input logic [2:0] ctrl);
    logic sum_v;
    logic cy_v;
    logic res_v;
    sum_v = a ^ b ^ cin;
    cy_v  = (a & b) | (a & cin) | (b & cin);
    case (ctrl)
      3'd2, 3'd3: res_v = sum_v;
      3'd4:       res_v = a & b;
      3'd5:       res_v = a | b;
      3'd6:       res_v = ~(a | b);
      3'd7:       res_v = a ^ b;
      default:    res_v = 1'b0;
    endcase
    return {cy_v, res_v};
  endfunction

  // Slice inputs for the current bit, and the result register after this bit is shifted in at the MSB.
  always_comb begin
    arith_s    = (ctrl_r[2:1] == 2'b01);
    illegal_s  = (ctrl_r[2:1] == 2'b00);
    b_bit_s    = b_r[idx_r] ^ (ctrl_r[0] & arith_s);
    slice_s    = alu_slice(a_r[idx_r], b_bit_s, carry_r, ctrl_r);
    res_next_s = {slice_s[0], res_r[WIDTH-1:1]};
    last_s     = (idx_r == LAST_IDX);
  end

  // Sequencer: IDLE/DONE accept a request, RUN steps one bit per edge, and the last bit publishes the result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      ctrl_r     <= 3'd0;
      idx_r      <= {IW{1'b0}};
      carry_r    <= 1'b0;
      c_in_msb_r <= 1'b0;
      res_r      <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      out_r      <= {WIDTH{1'b0}};
      carryout_r <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b1;
      negative_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.A;
            b_r     <= bus.B;
            ctrl_r  <= bus.control;
            idx_r   <= {IW{1'b0}};
            carry_r <= bus.control[0] & (bus.control[2:1] == 2'b01);
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          res_r   <= res_next_s;
          carry_r <= slice_s[1];
          idx_r   <= idx_r + IDX_ONE;
          if (idx_r == PRE_MSB_IDX) begin
            c_in_msb_r <= slice_s[1];
          end
          if (last_s) begin
            state_r    <= ST_DONE;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            out_r      <= illegal_s ? {WIDTH{1'b0}} : res_next_s;
            carryout_r <= arith_s & slice_s[1];
            overflow_r <= arith_s & (c_in_msb_r ^ slice_s[1]);
            zero_r     <= illegal_s | (res_next_s == {WIDTH{1'b0}});
            negative_r <= ~illegal_s & res_next_s[WIDTH-1];
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.out      = out_r;
  assign bus.carryout = carryout_r;
  assign bus.overflow = overflow_r;
  assign bus.zero     = zero_r;
  assign bus.negative = negative_r;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq: an arithmetic reference model checked every cycle,
// plus literal expectations for the headline vectors.
module tb_serial_alu_seq;
  localparam int         WIDTH  = 32;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOR = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  serial_alu_seq_if #(.WIDTH(WIDTH)) bus ();
  serial_alu_seq #(.WIDTH(WIDTH)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  bit   chk_en   = 1'b0;

  logic             m_busy;
  logic             m_done;
  logic [WIDTH-1:0] m_out;
  logic             m_cy;
  logic             m_ov;
  int               m_left;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  logic [2:0]       m_ctrl;

  // Reference result as {overflow, carryout, out}, from plain arithmetic.
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [2:0] ctrl);
    logic [WIDTH:0] s;
    logic           ov;
    case (ctrl)
      OP_ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        ov = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        return {ov, s[WIDTH], s[WIDTH-1:0]};
      end
      OP_SUB: begin
        s  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        ov = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        return {ov, s[WIDTH], s[WIDTH-1:0]};
      end
      OP_AND:  return {2'b00, a & b};
      OP_OR:   return {2'b00, a | b};
      OP_NOR:  return {2'b00, ~(a | b)};
      OP_XOR:  return {2'b00, a ^ b};
      default: return {(WIDTH+2){1'b0}};
    endcase
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a request is accepted when no op is pending, and the result appears WIDTH edges later.
  initial begin
    logic [WIDTH+1:0] r;
    m_busy = 1'b0; m_done = 1'b0; m_out = '0; m_cy = 1'b0; m_ov = 1'b0; m_left = 0;
    m_a = '0; m_b = '0; m_ctrl = 3'd0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_busy = 1'b0; m_done = 1'b0; m_out = '0; m_cy = 1'b0; m_ov = 1'b0; m_left = 0;
      end else begin
        m_done = 1'b0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            r      = ref_op(m_a, m_b, m_ctrl);
            m_out  = r[WIDTH-1:0];
            m_cy   = r[WIDTH];
            m_ov   = r[WIDTH+1];
            m_done = 1'b1;
            m_busy = 1'b0;
          end
        end else if (bus.start) begin
          m_a = bus.A; m_b = bus.B; m_ctrl = bus.control;
          m_left = WIDTH;
          m_busy = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.done) done_cnt++;
      if (chk_en) begin
        check("busy", bus.busy, m_busy);
        check("done", bus.done, m_done);
        check("out", bus.out, m_out);
        check("carryout", bus.carryout, m_cy);
        check("overflow", bus.overflow, m_ov);
        check("zero", bus.zero, (m_out == '0));
        check("negative", bus.negative, m_out[WIDTH-1]);
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] c);
    bus.A = a; bus.B = b; bus.control = c; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] c);
    int n;
    issue(a, b, c);
    wait_done(n);
    check({name, "_latency"}, n, 32'd32);
  endtask

  task automatic lit(input string name, input logic [WIDTH-1:0] o, input logic cy, input logic ov,
                     input logic z, input logic ng);
    check({name, "_out"}, bus.out, o);
    check({name, "_model_out"}, m_out, o);
    check({name, "_carryout"}, bus.carryout, cy);
    check({name, "_overflow"}, bus.overflow, ov);
    check({name, "_zero"}, bus.zero, z);
    check({name, "_negative"}, bus.negative, ng);
  endtask

  initial begin
    int n;
    int d0;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.control = 3'd0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    lit("rst", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clock);
    lit("idle", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, OP_ADD);
    lit("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    run_op("sub_eq", 32'd5, 32'd5, OP_SUB);
    lit("sub_eq", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_neg", 32'd0, 32'd1, OP_SUB);
    lit("sub_neg", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("nor", 32'hF0F0_F0F0, 32'hFF00_FF00, OP_NOR);
    lit("nor", 32'h000F_000F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, OP_XOR);
    lit("xor", 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND);
    run_op("or", 32'h1234_5678, 32'h8000_0001, OP_OR);
    run_op("sub_ovf", 32'h8000_0000, 32'h1, OP_SUB);
    run_op("add_cy", 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_ADD);
    run_op("illegal", 32'h1234_5678, 32'h9ABC_DEF0, 3'd1);
    lit("illegal", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // A start pulse during RUN must be ignored.
    repeat (3) @(negedge clock);
    d0 = done_cnt;
    issue(32'd3, 32'd4, OP_ADD);
    repeat (5) @(negedge clock);
    bus.A = 32'd1; bus.B = 32'd1; bus.control = OP_ADD; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(n);
    check("midrun_done_seen", bus.done, 1'b1);
    lit("midrun", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    check("midrun_done_count", done_cnt - d0, 32'd1);

    // A new request issued in the DONE cycle.
    run_op("back1", 32'd10, 32'd20, OP_ADD);
    run_op("back2", 32'd1, 32'd1, OP_ADD);
    lit("back2", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while bit 10 of a SUB is pending.
    run_op("pre_rst", 32'd0, 32'd1, OP_SUB);
    issue(32'd100, 32'd7, OP_SUB);
    repeat (10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    lit("abort", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    d0 = done_cnt;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("abort_no_done", done_cnt - d0, 32'd0);
    run_op("post_rst", 32'd2, 32'd2, OP_ADD);
    lit("post_rst", 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Bit-serial ALU sequencer: accepts a WIDTH-bit operation and executes it one bit per cycle through a single 1-bit ALU slice (full adder + logic unit + mux, same control encoding).
- Holds the ripple carry in a flop between cycles.
- Assembles the result in a shift register, then presents result and flags with a start/busy/done handshake.
- Sits between the register-read stage and writeback as the area-minimal ALU option.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).

Ports:
- clock     input   1      rising-edge clock
- reset_n   input   1      asynchronous, active-low reset
- start     input   1      request; sampled on clock edge when not busy
- A         input   WIDTH  operand A; sampled with start
- B         input   WIDTH  operand B; sampled with start
- control   input   3      2=ADD, 3=SUB, 4=AND, 5=OR, 6=NOR, 7=XOR; 0/1 are illegal
- busy      output  1      high while an operation is in progress
- done      output  1      one-cycle pulse when a result is published
- out       output  WIDTH  result, held until the next completion
- carryout  output  1      carry out of the MSB (arithmetic ops only)
- overflow  output  1      signed overflow (arithmetic ops only)
- zero      output  1      out == 0
- negative  output  1      out[WIDTH-1]

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset: state=IDLE; busy, done, out, carryout, overflow, negative = 0; zero = 1; internal regs cleared.
- Reset mid-operation: immediate abort with the same values as reset; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches A, B, control; bit index = 0; carry flop = control[0] & (control[2:1]==01), i.e. 1 only for SUB.
  - Goes to RUN.
- RUN (busy=1):
  - Each edge feeds A[i] and B[i] through the slice: B inverted when control[0] and arithmetic; carry-in = carry flop.
  - Shifts the slice output into the result register at bit i, stores the slice carry in the carry flop, and increments i.
  - Before the MSB step, saves the carry into the MSB as c_in_msb.
  - After the edge that processes bit WIDTH-1, goes to DONE.
- DONE (busy=0, done=1 for exactly this cycle):
  - out, carryout, overflow, zero and negative were updated on the entering edge.
  - Next edge: if start=1, accept the new op and go to RUN; otherwise go to IDLE.
- Latency:
  - start sampled at edge k; bit i processed at edge k+1+i.
  - Outputs update and done rises at edge k+WIDTH; done falls at edge k+WIDTH+1.
  - Throughput: one op per WIDTH+1 cycles.
- start while RUN: ignored; the operand inputs are don't-care.
- Arithmetic ops:
  - carryout = final carry flop; for SUB, 1 means no borrow.
  - overflow = c_in_msb XOR final carry.
- Logic ops: carryout = 0, overflow = 0; the carry flop is still updated but unused.
- Illegal control (0, 1):
  - Runs the full WIDTH cycles, then publishes out=0, carryout=0, overflow=0, zero=1, negative=0.
- Result flags: zero and negative are derived from the published out and stay stable between completions.
- Published outputs never change while RUN; out changes only on the DONE-entry edge.

Test Plan:
- Reset, then release: out=0, zero=1, busy=0, done=0. Hold start=0 for 10 cycles -> no change.
- ADD, WIDTH=32, A=0x7FFFFFFF, B=1, start at edge k -> busy during edges k+1..k+31, done high after edge k+32; out=0x80000000, overflow=1, carryout=0, negative=1, zero=0.
- SUB with A=5, B=5 -> out=0, zero=1, carryout=1, overflow=0. SUB with A=0, B=1 -> out=0xFFFFFFFF, carryout=0, negative=1, overflow=0.
- NOR with A=0xF0F0F0F0, B=0xFF00FF00 -> out=0x000F000F, carryout=0, overflow=0. XOR on the same operands -> 0x0FF00FF0. Control=1 -> out=0, zero=1.
- Pulse start with ADD 1+1 mid-RUN of an ADD 3+4 -> only 7 is published, one done pulse. Start held high in the DONE cycle with ADD 1+1 -> next result 2 after a further 32 edges.
- Assert reset_n low at bit 10 of a SUB -> outputs go to reset values immediately with no done pulse. New ADD 2+2 after release -> out=4.
